// File: rtl/fb_triple_buffer_ctrl_if.sv
// Framebuffer triple-buffer controller bus: capture write side, scan-out read side,
// and RAM-facing address/data outputs. The master drives the i_* signals, and the
// slave (the controller) drives the o_* signals.
interface fb_triple_buffer_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 15
);
  logic              i_wr_sof;
  logic              i_wr_eof;
  logic              i_wr_en;
  logic [ADDR_W-1:0] i_wr_addr;
  logic [DATA_W-1:0] i_wr_data;
  logic              i_rd_sof;
  logic [ADDR_W-1:0] i_rd_addr;
  logic              o_ram_we;
  logic [ADDR_W+1:0] o_ram_waddr;
  logic [DATA_W-1:0] o_ram_wdata;
  logic [ADDR_W+1:0] o_ram_raddr;
  logic              o_rd_blank;
  logic              o_fresh;
  logic [1:0]        o_disp_bank;

  modport master (
    output i_wr_sof, i_wr_eof, i_wr_en, i_wr_addr, i_wr_data, i_rd_sof, i_rd_addr,
    input  o_ram_we, o_ram_waddr, o_ram_wdata, o_ram_raddr, o_rd_blank, o_fresh, o_disp_bank
  );

  modport slave (
    input  i_wr_sof, i_wr_eof, i_wr_en, i_wr_addr, i_wr_data, i_rd_sof, i_rd_addr,
    output o_ram_we, o_ram_waddr, o_ram_wdata, o_ram_raddr, o_rd_blank, o_fresh, o_disp_bank
  );
endinterface

// File: rtl/fb_triple_buffer_ctrl.sv
// Triple-buffer scheduler for the shared capture framebuffer RAM.
// Rotates write/ready/display banks on frame boundaries and prefixes the bank
// index onto both RAM addresses. Optional macro FB_STATS_EN adds saturating
// dropped-frame and repeated-frame counters.
module fb_triple_buffer_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 15,
  parameter int FRAME_WORDS = 38400
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  fb_triple_buffer_ctrl_if.slave  bus
`ifdef FB_STATS_EN
  ,
  output logic [15:0]             o_drop_cnt,
  output logic [15:0]             o_rept_cnt
`endif
);

  typedef enum logic {ST_EMPTY, ST_RUN} state_t;

  localparam logic [ADDR_W:0] LP_FRAME = (ADDR_W+1)'(FRAME_WORDS);

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_wbank, r_rbank, r_dbank;
  logic [1:0]  w_wbank_nxt, w_rbank_nxt, w_dbank_nxt;
  logic        r_fresh, w_fresh_nxt;
  logic        r_wr_active, w_wr_active_nxt;
  logic        w_eof_valid;
  logic        w_disp_swap;
  logic [DATA_W-1:0] w_wdata;

  assign w_wdata         = bus.i_wr_data;
  assign bus.o_fresh     = r_fresh;
  assign bus.o_disp_bank = r_dbank;

  // State register: EMPTY until the first frame reaches the display.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_EMPTY;
    else       r_state <= w_state_nxt;
  end

  // Next-state: bank rotation, fresh flag, capture-active tracking.
  always_comb begin
    w_wbank_nxt     = r_wbank;
    w_rbank_nxt     = r_rbank;
    w_dbank_nxt     = r_dbank;
    w_fresh_nxt     = r_fresh;
    w_state_nxt     = r_state;
    w_eof_valid     = bus.i_wr_eof & r_wr_active;
    w_disp_swap     = bus.i_rd_sof & (w_eof_valid | r_fresh);
    // eof clears first, then a coincident sof re-arms for the next frame
    w_wr_active_nxt = bus.i_wr_sof ? 1'b1 : (bus.i_wr_eof ? 1'b0 : r_wr_active);

    if (w_eof_valid && bus.i_rd_sof) begin
      // completed frame bypasses ready and goes straight to display
      w_dbank_nxt = r_wbank;
      w_wbank_nxt = r_rbank;
      w_rbank_nxt = r_dbank;
      w_fresh_nxt = 1'b0;
    end else if (w_eof_valid) begin
      w_wbank_nxt = r_rbank;
      w_rbank_nxt = r_wbank;
      w_fresh_nxt = 1'b1;
    end else if (bus.i_rd_sof && r_fresh) begin
      w_dbank_nxt = r_rbank;
      w_rbank_nxt = r_dbank;
      w_fresh_nxt = 1'b0;
    end

    if (r_state == ST_EMPTY && w_disp_swap) w_state_nxt = ST_RUN;
  end

  // Bank/flag registers and the registered RAM write/read paths.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wbank          <= 2'd0;
      r_rbank          <= 2'd1;
      r_dbank          <= 2'd2;
      r_fresh          <= 1'b0;
      r_wr_active      <= 1'b0;
      bus.o_ram_we     <= 1'b0;
      bus.o_ram_waddr  <= '0;
      bus.o_ram_wdata  <= '0;
      bus.o_ram_raddr  <= '0;
      bus.o_rd_blank   <= 1'b1;
    end else begin
      r_wbank          <= w_wbank_nxt;
      r_rbank          <= w_rbank_nxt;
      r_dbank          <= w_dbank_nxt;
      r_fresh          <= w_fresh_nxt;
      r_wr_active      <= w_wr_active_nxt;
      bus.o_ram_we     <= bus.i_wr_en & r_wr_active & ({1'b0, bus.i_wr_addr} < LP_FRAME);
      bus.o_ram_waddr  <= {r_wbank, bus.i_wr_addr};
      bus.o_ram_wdata  <= w_wdata;
      bus.o_ram_raddr  <= {r_dbank, bus.i_rd_addr};
      bus.o_rd_blank   <= (r_state == ST_EMPTY) | ({1'b0, bus.i_rd_addr} >= LP_FRAME);
    end
  end

`ifdef FB_STATS_EN
  // Saturating counters: overwritten undisplayed frames and repeated display frames.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_drop_cnt <= '0;
      o_rept_cnt <= '0;
    end else begin
      if (w_eof_valid && r_fresh && !bus.i_rd_sof && o_drop_cnt != '1)
        o_drop_cnt <= o_drop_cnt + 16'd1;
      if (bus.i_rd_sof && r_state == ST_RUN && !r_fresh && !w_eof_valid && o_rept_cnt != '1)
        o_rept_cnt <= o_rept_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fb_triple_buffer_ctrl.sv
// Bench for fb_triple_buffer_ctrl: table-driven vectors plus hand-written
// sequences, with expected outputs queued at drive time and checked after the edge.
module tb_fb_triple_buffer_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fb_triple_buffer_ctrl_if #(.ADDR_W(16), .DATA_W(15)) bus ();

`ifdef FB_STATS_EN
  logic [15:0] drop_cnt, rept_cnt;
`endif

  fb_triple_buffer_ctrl #(.ADDR_W(16), .DATA_W(15), .FRAME_WORDS(38400)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
`ifdef FB_STATS_EN
    ,
    .o_drop_cnt (drop_cnt),
    .o_rept_cnt (rept_cnt)
`endif
  );

  typedef struct {
    logic        we;
    logic [17:0] waddr;
    logic [14:0] wdata;
    logic [17:0] raddr;
    logic        blank;
    logic        fresh;
    logic [1:0]  disp;
    logic [15:0] drop;
    logic [15:0] rept;
  } exp_t;

  typedef struct {
    logic        rst;
    logic        wsof;
    logic        weof;
    logic        wen;
    logic [15:0] wa;
    logic [14:0] wd;
    logic        rsof;
    logic [15:0] ra;
    exp_t        e;
  } vec_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic exp_t E(logic we, logic [17:0] wa, logic [14:0] wd, logic [17:0] ra,
                             logic bl, logic fr, logic [1:0] dp, logic [15:0] dr, logic [15:0] rp);
    exp_t e;
    e.we = we; e.waddr = wa; e.wdata = wd; e.raddr = ra; e.blank = bl;
    e.fresh = fr; e.disp = dp; e.drop = dr; e.rept = rp;
    return e;
  endfunction

  function automatic vec_t V(logic r, logic ws, logic we_, logic en, logic [15:0] wa,
                             logic [14:0] wd, logic rs, logic [15:0] ra, exp_t e);
    vec_t v;
    v.rst = r; v.wsof = ws; v.weof = we_; v.wen = en; v.wa = wa; v.wd = wd;
    v.rsof = rs; v.ra = ra; v.e = e;
    return v;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic check();
    exp_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard: got empty queue expected one entry");
      return;
    end
    e = exp_q.pop_front();
    cmp("ram_we",    32'(bus.o_ram_we),    32'(e.we));
    cmp("ram_waddr", 32'(bus.o_ram_waddr), 32'(e.waddr));
    cmp("ram_wdata", 32'(bus.o_ram_wdata), 32'(e.wdata));
    cmp("ram_raddr", 32'(bus.o_ram_raddr), 32'(e.raddr));
    cmp("rd_blank",  32'(bus.o_rd_blank),  32'(e.blank));
    cmp("fresh",     32'(bus.o_fresh),     32'(e.fresh));
    cmp("disp_bank", 32'(bus.o_disp_bank), 32'(e.disp));
`ifdef FB_STATS_EN
    cmp("drop_cnt",  32'(drop_cnt),        32'(e.drop));
    cmp("rept_cnt",  32'(rept_cnt),        32'(e.rept));
`endif
  endtask

  task automatic step(input vec_t v);
    rst          = v.rst;
    bus.i_wr_sof = v.wsof;
    bus.i_wr_eof = v.weof;
    bus.i_wr_en  = v.wen;
    bus.i_wr_addr = v.wa;
    bus.i_wr_data = v.wd;
    bus.i_rd_sof = v.rsof;
    bus.i_rd_addr = v.ra;
    exp_q.push_back(v.e);
    @(posedge clk);
    #1;
    check();
  endtask

  // Two reset cycles; outputs must show reset values.
  task automatic do_reset();
    for (int i = 0; i < 2; i++)
      step(V(1, 0, 0, 1, 16'd3, 15'd3, 1, 16'd3, E(0, 0, 0, 0, 1, 0, 2, 0, 0)));
  endtask

  vec_t tbl[14];

  initial begin
    bus.i_wr_sof = 0; bus.i_wr_eof = 0; bus.i_wr_en = 0; bus.i_wr_addr = '0;
    bus.i_wr_data = '0; bus.i_rd_sof = 0; bus.i_rd_addr = '0;

    //           rst sof eof en  waddr        wdata     rsof raddr          we  waddr       wdata     raddr       bl fr dp dr rp
    tbl[0]  = V(0, 0, 0, 1, 16'd5,     15'h123,  0, 16'd5,     E(0, 18'h00005, 15'h123,  18'h20005, 1, 0, 2, 0, 0));
    tbl[1]  = V(0, 0, 1, 0, 16'd0,     15'h0,    0, 16'd0,     E(0, 18'h00000, 15'h0,    18'h20000, 1, 0, 2, 0, 0));
    tbl[2]  = V(0, 0, 0, 0, 16'd0,     15'h0,    0, 16'd0,     E(0, 18'h00000, 15'h0,    18'h20000, 1, 0, 2, 0, 0));
    tbl[3]  = V(0, 1, 0, 1, 16'd7,     15'h7,    0, 16'd0,     E(0, 18'h00007, 15'h7,    18'h20000, 1, 0, 2, 0, 0));
    tbl[4]  = V(0, 0, 0, 1, 16'd38400, 15'h1,    0, 16'd0,     E(0, 18'h09600, 15'h1,    18'h20000, 1, 0, 2, 0, 0));
    tbl[5]  = V(0, 0, 0, 1, 16'd38399, 15'h7FFF, 0, 16'd0,     E(1, 18'h095FF, 15'h7FFF, 18'h20000, 1, 0, 2, 0, 0));
    tbl[6]  = V(0, 0, 1, 1, 16'd3,     15'h55,   0, 16'd0,     E(1, 18'h00003, 15'h55,   18'h20000, 1, 1, 2, 0, 0));
    tbl[7]  = V(0, 0, 0, 0, 16'd0,     15'h0,    0, 16'd0,     E(0, 18'h10000, 15'h0,    18'h20000, 1, 1, 2, 0, 0));
    tbl[8]  = V(0, 0, 0, 1, 16'd3,     15'h9,    0, 16'd0,     E(0, 18'h10003, 15'h9,    18'h20000, 1, 1, 2, 0, 0));
    tbl[9]  = V(0, 0, 0, 0, 16'd0,     15'h0,    1, 16'd0,     E(0, 18'h10000, 15'h0,    18'h20000, 1, 0, 0, 0, 0));
    tbl[10] = V(0, 0, 0, 0, 16'd0,     15'h0,    0, 16'd0,     E(0, 18'h10000, 15'h0,    18'h00000, 0, 0, 0, 0, 0));
    tbl[11] = V(0, 0, 0, 0, 16'd0,     15'h0,    0, 16'd38400, E(0, 18'h10000, 15'h0,    18'h09600, 1, 0, 0, 0, 0));
    tbl[12] = V(0, 0, 0, 0, 16'd0,     15'h0,    0, 16'd38399, E(0, 18'h10000, 15'h0,    18'h095FF, 0, 0, 0, 0, 0));
    tbl[13] = V(0, 0, 0, 0, 16'd0,     15'h0,    1, 16'd1,     E(0, 18'h10000, 15'h0,    18'h00001, 0, 0, 0, 0, 1));

    do_reset();
    foreach (tbl[i]) step(tbl[i]);

    // Full frame: 38400 writes into bank 0, then display swap, then check R=2.
    do_reset();
    step(V(0, 1, 0, 0, 16'd0, 15'd0, 0, 16'd0, E(0, 18'h00000, 15'd0, 18'h20000, 1, 0, 2, 0, 0)));
    for (int i = 0; i < 38400; i++)
      step(V(0, 0, 0, 1, 16'(i), 15'(i), 0, 16'd0,
             E(1, {2'd0, 16'(i)}, 15'(i), 18'h20000, 1, 0, 2, 0, 0)));
    step(V(0, 0, 1, 0, 16'd0, 15'd0, 0, 16'd0, E(0, 18'h00000, 15'd0, 18'h20000, 1, 1, 2, 0, 0)));
    step(V(0, 0, 0, 1, 16'd0, 15'd0, 0, 16'd0, E(0, 18'h10000, 15'd0, 18'h20000, 1, 1, 2, 0, 0)));
    step(V(0, 0, 0, 0, 16'd0, 15'd0, 1, 16'd0, E(0, 18'h10000, 15'd0, 18'h20000, 1, 0, 0, 0, 0)));
    step(V(0, 0, 0, 0, 16'd0, 15'd0, 0, 16'd0, E(0, 18'h10000, 15'd0, 18'h00000, 0, 0, 0, 0, 0)));
    step(V(0, 1, 0, 0, 16'd0, 15'd0, 0, 16'd0, E(0, 18'h10000, 15'd0, 18'h00000, 0, 0, 0, 0, 0)));
    step(V(0, 0, 1, 0, 16'd0, 15'd0, 0, 16'd0, E(0, 18'h10000, 15'd0, 18'h00000, 0, 1, 0, 0, 0)));
    step(V(0, 0, 0, 1, 16'd0, 15'd0, 0, 16'd0, E(0, 18'h20000, 15'd0, 18'h00000, 0, 1, 0, 0, 0)));

    // Back-to-back frames (eof+sof same cycle), second eof overwrites an undisplayed frame,
    // then a valid eof coincident with rd_sof from W=0,R=1,D=2.
    do_reset();
    step(V(0, 1, 0, 0, 16'd0, 15'd0, 0, 16'd0, E(0, 18'h00000, 15'd0, 18'h20000, 1, 0, 2, 0, 0)));
    step(V(0, 1, 1, 0, 16'd0, 15'd0, 0, 16'd0, E(0, 18'h00000, 15'd0, 18'h20000, 1, 1, 2, 0, 0)));
    step(V(0, 0, 0, 1, 16'd9, 15'd9, 0, 16'd0, E(1, 18'h10009, 15'd9, 18'h20000, 1, 1, 2, 0, 0)));
    step(V(0, 0, 1, 0, 16'd0, 15'd0, 0, 16'd0, E(0, 18'h10000, 15'd0, 18'h20000, 1, 1, 2, 1, 0)));
    step(V(0, 0, 0, 1, 16'd9, 15'd9, 0, 16'd0, E(0, 18'h00009, 15'd9, 18'h20000, 1, 1, 2, 1, 0)));
    step(V(0, 1, 0, 0, 16'd0, 15'd0, 0, 16'd0, E(0, 18'h00000, 15'd0, 18'h20000, 1, 1, 2, 1, 0)));
    step(V(0, 0, 1, 0, 16'd0, 15'd0, 1, 16'd0, E(0, 18'h00000, 15'd0, 18'h20000, 1, 0, 0, 1, 0)));
    step(V(0, 0, 0, 1, 16'd2, 15'd2, 0, 16'd4, E(0, 18'h10002, 15'd2, 18'h00004, 0, 0, 0, 1, 0)));
    step(V(0, 0, 0, 0, 16'd0, 15'd0, 1, 16'd0, E(0, 18'h10000, 15'd0, 18'h00000, 0, 0, 0, 1, 1)));
    step(V(0, 1, 0, 0, 16'd0, 15'd0, 0, 16'd0, E(0, 18'h10000, 15'd0, 18'h00000, 0, 0, 0, 1, 1)));
    step(V(0, 0, 1, 0, 16'd0, 15'd0, 0, 16'd0, E(0, 18'h10000, 15'd0, 18'h00000, 0, 1, 0, 1, 1)));
    step(V(0, 0, 0, 1, 16'd0, 15'd0, 0, 16'd0, E(0, 18'h20000, 15'd0, 18'h00000, 0, 1, 0, 1, 1)));

    // Reset mid-frame, then a stray eof must be ignored.
    do_reset();
    step(V(0, 1, 0, 0, 16'd0, 15'd0, 0, 16'd0, E(0, 18'h00000, 15'd0, 18'h20000, 1, 0, 2, 0, 0)));
    step(V(0, 0, 0, 1, 16'd1, 15'd1, 0, 16'd0, E(1, 18'h00001, 15'd1, 18'h20000, 1, 0, 2, 0, 0)));
    step(V(1, 0, 0, 1, 16'd2, 15'd2, 0, 16'd0, E(0, 18'h00000, 15'd0, 18'h00000, 1, 0, 2, 0, 0)));
    step(V(0, 0, 1, 0, 16'd0, 15'd0, 0, 16'd0, E(0, 18'h00000, 15'd0, 18'h20000, 1, 0, 2, 0, 0)));
    step(V(0, 0, 0, 1, 16'd4, 15'd4, 0, 16'd0, E(0, 18'h00004, 15'd4, 18'h20000, 1, 0, 2, 0, 0)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
